// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit seven-segment driver with one-deep update buffer.
// New values are committed only at frame boundaries so a frame never mixes old and new data.
module seg_scan #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_blank,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned IW  = 3;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] shown_data;
  logic [BW-1:0] shown_blank;
  logic [DW-1:0] pend_data;
  logic [BW-1:0] pend_blank;
  logic          pend_full;

  logic          tick;
  logic          boundary;
  logic          accept;
  logic [3:0]    nib;

  assign tick     = (cnt == CW'(DIV - 1));
  assign boundary = tick && (idx == IW'(7));
  assign accept   = in_valid && !pend_full;
  assign in_ready = !pend_full;

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + IW'(1);
    end
  end

  // Pending buffer and frame-boundary commit; commit and accept are mutually exclusive on pend_full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_data  <= '0;
      shown_blank <= '1;
      pend_data   <= '0;
      pend_blank  <= '0;
      pend_full   <= 1'b0;
    end else begin
      if (boundary && pend_full) begin
        shown_data  <= pend_data;
        shown_blank <= pend_blank;
        pend_full   <= 1'b0;
      end else if (accept) begin
        pend_data   <= in_data;
        pend_blank  <= in_blank;
        pend_full   <= 1'b1;
      end
    end
  end

  assign an  = ~(BW'(1) << idx);
  assign nib = shown_data[{idx, 2'b00} +: 4];

  // Active-low hex decode, segments a..g on bits 6..0
  always_comb begin
    seg = 7'b1111111;
    if (!shown_blank[idx]) begin
      case (nib)
        4'h0:    seg = 7'b0000001;
        4'h1:    seg = 7'b1001111;
        4'h2:    seg = 7'b0010010;
        4'h3:    seg = 7'b0000110;
        4'h4:    seg = 7'b1001100;
        4'h5:    seg = 7'b0100100;
        4'h6:    seg = 7'b0100000;
        4'h7:    seg = 7'b0001111;
        4'h8:    seg = 7'b0000000;
        4'h9:    seg = 7'b0000100;
        4'hA:    seg = 7'b0001000;
        4'hB:    seg = 7'b1100000;
        4'hC:    seg = 7'b0110001;
        4'hD:    seg = 7'b1000010;
        4'hE:    seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan at DIV=4: stimulus queues expected an/seg/in_ready per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_seg_scan;

  localparam int unsigned DIV = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_blank;
  logic [7:0]  an;
  logic [6:0]  seg;

  typedef struct {
    string      name;
    logic [7:0] an;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  seg_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_blank(in_blank), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Hand-written segment table, independent of the DUT case statement
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  function automatic logic [6:0] segexp(input logic [31:0] d, input logic [7:0] b, input int k);
    logic [3:0] n;
    n = d[k*4 +: 4];
    if (b[k]) return 7'b1111111;
    return hexseg(n);
  endfunction

  function automatic logic [7:0] anexp(input int k);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << k);
  endfunction

  // Queue the expectation for the current cycle, then advance one clock
  task automatic cyc(input string nm, input logic [7:0] ean, input logic [6:0] eseg, input logic erdy);
    exp_t e;
    e.name = nm; e.an = ean; e.seg = eseg; e.rdy = erdy;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pos(input string nm, input int p, input logic [31:0] d, input logic [7:0] b,
                           input logic rdy);
    cyc(nm, anexp(p / DIV), segexp(d, b, p / DIV), rdy);
  endtask

  task automatic frame(input string nm, input logic [31:0] d, input logic [7:0] b, input logic rdy);
    for (int p = 0; p < FRAME; p++) frame_pos(nm, p, d, b, rdy);
  endtask

  // Offer an update at frame position 0 while showing old data; it appears one frame later
  task automatic accept_at_start(input string nm, input logic [31:0] d, input logic [7:0] b,
                                 input logic [31:0] od, input logic [7:0] ob);
    in_valid = 1'b1; in_data = d; in_blank = b;
    frame_pos({nm, "_acc"}, 0, od, ob, 1'b1);
    in_valid = 1'b0; in_data = 32'h0; in_blank = 8'h0;
    for (int p = 1; p < FRAME; p++) frame_pos({nm, "_hold"}, p, od, ob, 1'b0);
    frame(nm, d, b, 1'b1);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || in_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s t=%0t an=%h seg=%b rdy=%b expected an=%h seg=%b rdy=%b",
                 e.name, $time, an, seg, in_ready, e.an, e.seg, e.rdy);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; in_blank = 8'h00;

    // Reset held with an offer present: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cyc("reset", 8'hFE, 7'h7F, 1'b1);
    end
    rst = 1'b0; in_valid = 1'b0; in_data = 32'h0;

    // Scan order, all digits blank from reset
    frame("scan", 32'h0, 8'hFF, 1'b1);

    accept_at_start("dec_fedc", 32'hFEDCBA98, 8'h00, 32'h0, 8'hFF);
    accept_at_start("dec_7654", 32'h76543210, 8'h00, 32'hFEDCBA98, 8'h00);
    accept_at_start("blank_aa", 32'h00000000, 8'hAA, 32'h76543210, 8'h00);

    // Tear-free: A offered at digit 3, B offered while pending full
    for (int p = 0; p < 3 * DIV; p++) frame_pos("tear_old", p, 32'h0, 8'hAA, 1'b1);
    in_valid = 1'b1; in_data = 32'h89ABCDEF; in_blank = 8'h00;
    frame_pos("tear_accA", 3 * DIV, 32'h0, 8'hAA, 1'b1);
    in_data = 32'h01234567; in_blank = 8'h0F;
    for (int p = 3 * DIV + 1; p < FRAME; p++) frame_pos("tear_oldB", p, 32'h0, 8'hAA, 1'b0);
    frame_pos("tear_A_accB", 0, 32'h89ABCDEF, 8'h00, 1'b1);
    in_valid = 1'b0; in_data = 32'h0; in_blank = 8'h0;
    for (int p = 1; p < FRAME; p++) frame_pos("tear_A", p, 32'h89ABCDEF, 8'h00, 1'b0);
    frame("tear_B", 32'h01234567, 8'h0F, 1'b1);

    // Reset at digit 5 with pending full; pending must never appear
    in_valid = 1'b1; in_data = 32'hCCCCCCCC; in_blank = 8'h00;
    frame_pos("rstm_acc", 0, 32'h01234567, 8'h0F, 1'b1);
    in_valid = 1'b0;
    for (int p = 1; p < 5 * DIV; p++) frame_pos("rstm_pre", p, 32'h01234567, 8'h0F, 1'b0);
    rst = 1'b1;
    cyc("rstm_hold", 8'hFE, 7'h7F, 1'b1);
    cyc("rstm_hold", 8'hFE, 7'h7F, 1'b1);
    rst = 1'b0;
    frame("rstm_post1", 32'h0, 8'hFF, 1'b1);
    frame("rstm_post2", 32'h0, 8'hFF, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
